// File: rtl/noc_inject_arbiter_pkg.sv
// Shared types and helpers for the NoC injection arbiter: FSM state encoding
// and a clog2 that never returns zero, so index fields always have at least one bit.
package noc_inject_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Requester/router bundle for the injection arbiter. The master side is the
// PE/router environment; the slave side is the arbiter itself.
interface noc_inject_arbiter_if import noc_inject_arbiter_pkg::*; #(
  parameter int N          = 4,
  parameter int X_SIZE     = 1,
  parameter int Y_SIZE     = 1,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 16
);

  localparam int IDX_W   = clog2(N);
  localparam int TOTAL_W = X_SIZE + Y_SIZE + DATA_WIDTH;

  logic [N-1:0]            req_valid;
  logic [N*X_SIZE-1:0]     req_dst_x;
  logic [N*Y_SIZE-1:0]     req_dst_y;
  logic [N*DATA_WIDTH-1:0] req_data;
  logic [N-1:0]            req_ready;
  logic                    noc_valid;
  logic [TOTAL_W-1:0]      noc_data;
  logic                    noc_ready;
  logic [IDX_W-1:0]        grant_id;
  logic                    drop_pulse;
  logic [N*CNT_W-1:0]      stat_grant;
  logic [CNT_W-1:0]        stat_drop;

  modport master (
    output req_valid, req_dst_x, req_dst_y, req_data, noc_ready,
    input  req_ready, noc_valid, noc_data, grant_id, drop_pulse, stat_grant, stat_drop
  );

  modport slave (
    input  req_valid, req_dst_x, req_dst_y, req_data, noc_ready,
    output req_ready, noc_valid, noc_data, grant_id, drop_pulse, stat_grant, stat_drop
  );

endinterface

// File: rtl/noc_inject_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after ptr_i,
// wrapping modulo N, returned as one-hot and as an index.
module rr_arbiter import noc_inject_arbiter_pkg::*; #(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] idx;

  // Scan from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int off = N; off >= 1; off--) begin
      idx = IDX_W'((int'(ptr_i) + off) % N);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Round-robin sharing of one router PE injection port among N requesters, with
// destination range check/drop. Per-requester stats are built only with NOC_ARB_STATS_EN.
module noc_inject_arbiter import noc_inject_arbiter_pkg::*; #(
  parameter int N          = 4,
  parameter int X          = 2,
  parameter int Y          = 2,
  parameter int DATA_WIDTH = 32,
  parameter int X_SIZE     = 1,
  parameter int Y_SIZE     = 1,
  parameter int CNT_W      = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  noc_inject_arbiter_if.slave bus
);

  localparam int IDX_W      = clog2(N);
  localparam int TOTAL_W    = X_SIZE + Y_SIZE + DATA_WIDTH;
  localparam int FLIT_X_LSB = DATA_WIDTH;
  localparam int FLIT_Y_LSB = DATA_WIDTH + X_SIZE;

  arb_state_e             state_q, state_d;
  logic [TOTAL_W-1:0]     data_q, data_d;
  logic [IDX_W-1:0]       gid_q, gid_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   drop_q, drop_d;

  logic [N-1:0]           gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   any;
  logic                   can_accept;
  logic                   accept;
  logic                   in_range;
  logic [X_SIZE-1:0]      sel_x;
  logic [Y_SIZE-1:0]      sel_y;
  logic [DATA_WIDTH-1:0]  sel_data;

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_rr (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any)
  );

  assign can_accept = (state_q == EMPTY) || bus.noc_ready;
  assign accept     = can_accept && any;

  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        sel_x    = bus.req_dst_x[i*X_SIZE +: X_SIZE];
        sel_y    = bus.req_dst_y[i*Y_SIZE +: Y_SIZE];
        sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A field wide enough only for legal coordinates needs no compare at all.
  assign in_range = ((X >= (1 << X_SIZE)) || (32'(sel_x) < 32'(X))) &&
                    ((Y >= (1 << Y_SIZE)) || (32'(sel_y) < 32'(Y)));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    drop_d  = 1'b0;
    if (state_q == FULL && bus.noc_ready) state_d = EMPTY;
    if (accept) begin
      ptr_d = gnt_idx;
      if (in_range) begin
        state_d                           = FULL;
        data_d[DATA_WIDTH-1:0]            = sel_data;
        data_d[FLIT_X_LSB +: X_SIZE]      = sel_x;
        data_d[FLIT_Y_LSB +: Y_SIZE]      = sel_y;
        gid_d                             = gnt_idx;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // Pointer resets to N-1 so requester 0 is first in line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= IDX_W'(N - 1);
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.req_ready  = can_accept ? gnt : '0;
  assign bus.noc_valid  = (state_q == FULL);
  assign bus.noc_data   = data_q;
  assign bus.grant_id   = gid_q;
  assign bus.drop_pulse = drop_q;

`ifdef NOC_ARB_STATS_EN
  logic [CNT_W-1:0]   grant_cnt_q [N];
  logic [CNT_W-1:0]   grant_cnt_d [N];
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [N*CNT_W-1:0] stat_grant_flat;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (accept && in_range && grant_cnt_q[gnt_idx] != '1)
      grant_cnt_d[gnt_idx] = grant_cnt_q[gnt_idx] + 1'b1;
    if (accept && !in_range && drop_cnt_q != '1)
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) grant_cnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_comb begin
    stat_grant_flat = '0;
    for (int i = 0; i < N; i++) stat_grant_flat[i*CNT_W +: CNT_W] = grant_cnt_q[i];
  end

  assign bus.stat_grant = stat_grant_flat;
  assign bus.stat_drop  = drop_cnt_q;
`else
  assign bus.stat_grant = '0;
  assign bus.stat_drop  = '0;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Self-checking bench for noc_inject_arbiter on a 3x2 mesh (2-bit dst_x), 4-bit stats.
// Expected values come from directed constants and a cycle-level reference model.
module tb_noc_inject_arbiter;

  localparam int N  = 4;
  localparam int X  = 3;
  localparam int Y  = 2;
  localparam int XS = 2;
  localparam int YS = 1;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int TW = XS + YS + DW;

  logic clk;
  logic rst;

  logic [N-1:0]  reqValid;
  logic [XS-1:0] dstX [N];
  logic [YS-1:0] dstY [N];
  logic [DW-1:0] payload [N];
  logic          nocReady;

  bit            mFull;
  logic [TW-1:0] mData;
  int            mGid;
  int            mPtr;
  bit            mDrop;
  int            mGrantCnt [N];
  int            mDropCnt;

  logic [N-1:0]    expReady, obsReady;
  logic            obsValid, obsDrop;
  logic [TW-1:0]   obsData;
  logic [1:0]      obsGid;
  logic [N*CW-1:0] obsStatGrant, expStatGrant;
  logic [CW-1:0]   obsStatDrop, expStatDrop;

  int vectors;
  int miscompares;
  int cycleNo;

  noc_inject_arbiter_if #(.N(N), .X_SIZE(XS), .Y_SIZE(YS), .DATA_WIDTH(DW), .CNT_W(CW)) bus ();

  noc_inject_arbiter #(
    .N(N), .X(X), .Y(Y), .DATA_WIDTH(DW), .X_SIZE(XS), .Y_SIZE(YS), .CNT_W(CW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    mFull = 0; mData = '0; mGid = 0; mPtr = N - 1; mDrop = 0; mDropCnt = 0;
    for (int i = 0; i < N; i++) mGrantCnt[i] = 0;
  endtask

  // Drives one cycle of stimulus, steps the model alongside the DUT and
  // captures the DUT's combinational and registered outputs.
  task automatic applyStimulus();
    int  g;
    bit  any;
    bit  can;
    bus.req_valid = reqValid;
    bus.noc_ready = nocReady;
    for (int i = 0; i < N; i++) begin
      bus.req_dst_x[i*XS +: XS] = dstX[i];
      bus.req_dst_y[i*YS +: YS] = dstY[i];
      bus.req_data[i*DW +: DW]  = payload[i];
    end
    #4;
    can = !mFull || (nocReady == 1'b1);
    any = 0;
    g   = 0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (mPtr + k) % N;
      if (!any && reqValid[idx]) begin
        any = 1;
        g   = idx;
      end
    end
    expReady = (can && any) ? (4'(1) << g) : '0;
    obsReady = bus.req_ready;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      mDrop = 0;
      if (mFull && nocReady) mFull = 0;
      if (can && any) begin
        mPtr = g;
        if (int'(dstX[g]) < X && int'(dstY[g]) < Y) begin
          mFull = 1;
          mData = {dstY[g], dstX[g], payload[g]};
          mGid  = g;
          if (mGrantCnt[g] < (1 << CW) - 1) mGrantCnt[g]++;
        end else begin
          mDrop = 1;
          if (mDropCnt < (1 << CW) - 1) mDropCnt++;
        end
      end
    end
    #1;
    cycleNo++;
    obsValid     = bus.noc_valid;
    obsData      = bus.noc_data;
    obsGid       = bus.grant_id;
    obsDrop      = bus.drop_pulse;
    obsStatGrant = bus.stat_grant;
    obsStatDrop  = bus.stat_drop;
`ifdef NOC_ARB_STATS_EN
    for (int i = 0; i < N; i++) expStatGrant[i*CW +: CW] = CW'(mGrantCnt[i]);
    expStatDrop = CW'(mDropCnt);
`else
    expStatGrant = '0;
    expStatDrop  = '0;
`endif
  endtask

  task automatic set_idle();
    reqValid = '0;
    nocReady = 1'b1;
    rst      = 1'b0;
    for (int i = 0; i < N; i++) begin
      dstX[i] = '0; dstY[i] = '0; payload[i] = '0;
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    reqValid = '1;
    applyStimulus();
    applyStimulus();
    vectors += 6;
    if (obsValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got=%b exp=0", obsValid); end
    if (obsData !== '0) begin miscompares++; $display("[TB] FAIL reset_data got=%h exp=0", obsData); end
    if (obsGid !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_gid got=%0d exp=0", obsGid); end
    if (obsDrop !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_drop got=%b exp=0", obsDrop); end
    if (obsStatGrant !== '0) begin miscompares++; $display("[TB] FAIL reset_stat_grant got=%h exp=0", obsStatGrant); end
    if (obsStatDrop !== '0) begin miscompares++; $display("[TB] FAIL reset_stat_drop got=%h exp=0", obsStatDrop); end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [TW-1:0] expData;
    set_idle();
    reqValid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      dstX[i] = XS'(i % X); dstY[i] = YS'(i % Y); payload[i] = $urandom;
    end
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      expData = {dstY[c % N], dstX[c % N], payload[c % N]};
      vectors += 4;
      if (obsReady !== (4'(1) << (c % N))) begin miscompares++; $display("[TB] FAIL rr_ready c=%0d got=%b exp=%b", c, obsReady, 4'(1) << (c % N)); end
      if (obsGid !== 2'(c % N)) begin miscompares++; $display("[TB] FAIL rr_gid c=%0d got=%0d exp=%0d", c, obsGid, c % N); end
      if (obsValid !== 1'b1) begin miscompares++; $display("[TB] FAIL rr_valid c=%0d got=%b exp=1", c, obsValid); end
      if (obsData !== expData) begin miscompares++; $display("[TB] FAIL rr_data c=%0d got=%h exp=%h", c, obsData, expData); end
    end
  endtask

  task automatic test_stall();
    set_idle();
    applyStimulus();
    reqValid = 4'b0010; dstX[1] = 2'd1; dstY[1] = 1'b1; payload[1] = 32'hA5A5A5A5;
    nocReady = 1'b0;
    applyStimulus();
    vectors++;
    if (obsReady !== 4'b0010) begin miscompares++; $display("[TB] FAIL stall_accept got=%b exp=0010", obsReady); end
    reqValid = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      vectors += 4;
      if (obsReady !== 4'b0000) begin miscompares++; $display("[TB] FAIL stall_ready c=%0d got=%b exp=0000", c, obsReady); end
      if (obsValid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_valid c=%0d got=%b exp=1", c, obsValid); end
      if (obsData !== 35'h5A5A5A5A5) begin miscompares++; $display("[TB] FAIL stall_data c=%0d got=%h exp=5a5a5a5a5", c, obsData); end
      if (obsGid !== 2'd1) begin miscompares++; $display("[TB] FAIL stall_gid c=%0d got=%0d exp=1", c, obsGid); end
    end
    reqValid = '0;
    nocReady = 1'b1;
    applyStimulus();
    vectors++;
    if (obsValid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_release got=%b exp=0", obsValid); end
  endtask

  task automatic test_drop();
    set_idle();
    applyStimulus();
    reqValid = 4'b0100; dstX[2] = 2'd3; dstY[2] = 1'b0; payload[2] = $urandom;
    applyStimulus();
    vectors += 4;
    if (obsReady !== 4'b0100) begin miscompares++; $display("[TB] FAIL drop_ready got=%b exp=0100", obsReady); end
    if (obsDrop !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_pulse got=%b exp=1", obsDrop); end
    if (obsValid !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_valid got=%b exp=0", obsValid); end
    if (obsStatDrop !== expStatDrop) begin miscompares++; $display("[TB] FAIL drop_stat got=%0d exp=%0d", obsStatDrop, expStatDrop); end
    reqValid = '0;
    applyStimulus();
    vectors++;
    if (obsDrop !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_one_cycle got=%b exp=0", obsDrop); end
  endtask

  task automatic test_priority();
    set_idle();
    applyStimulus();
    reqValid = 4'b0001;
    applyStimulus();
    reqValid = 4'b1001;
    applyStimulus();
    vectors++;
    if (obsGid !== 2'd3) begin miscompares++; $display("[TB] FAIL prio_first got=%0d exp=3", obsGid); end
    applyStimulus();
    vectors++;
    if (obsGid !== 2'd0) begin miscompares++; $display("[TB] FAIL prio_second got=%0d exp=0", obsGid); end
  endtask

  task automatic test_reset_mid();
    set_idle();
    applyStimulus();
    reqValid = 4'b0010; dstX[1] = 2'd2; nocReady = 1'b0;
    applyStimulus();
    reqValid = '0;
    applyStimulus();
    vectors++;
    if (obsValid !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_full got=%b exp=1", obsValid); end
    rst = 1'b1;
    applyStimulus();
    vectors++;
    if (obsValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_valid got=%b exp=0", obsValid); end
    rst = 1'b0;
    reqValid = 4'b0110; nocReady = 1'b1;
    applyStimulus();
    vectors += 2;
    if (obsGid !== 2'd1) begin miscompares++; $display("[TB] FAIL rstmid_gid got=%0d exp=1", obsGid); end
    if (obsValid !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_regrant got=%b exp=1", obsValid); end
  endtask

  task automatic test_saturate();
    logic [CW-1:0] expCnt;
    set_idle();
    reqValid = 4'b0100; dstX[2] = 2'd1; dstY[2] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      payload[2] = $urandom;
      applyStimulus();
    end
`ifdef NOC_ARB_STATS_EN
    expCnt = 4'd15;
`else
    expCnt = 4'd0;
`endif
    vectors += 2;
    if (obsStatGrant[2*CW +: CW] !== expCnt) begin miscompares++; $display("[TB] FAIL sat_cnt2 got=%0d exp=%0d", obsStatGrant[2*CW +: CW], expCnt); end
    if (obsStatGrant !== expStatGrant) begin miscompares++; $display("[TB] FAIL sat_all got=%h exp=%h", obsStatGrant, expStatGrant); end
  endtask

  task automatic test_random();
    set_idle();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 59) == 0);
      nocReady = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        reqValid[i] = ($urandom_range(0, 2) != 0);
        dstX[i]     = XS'($urandom_range(0, 3));
        dstY[i]     = YS'($urandom_range(0, 1));
        payload[i]  = $urandom;
      end
      applyStimulus();
      vectors += 7;
      if (obsReady !== expReady) begin miscompares++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", cycleNo, obsReady, expReady); end
      if (obsValid !== 1'(mFull)) begin miscompares++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", cycleNo, obsValid, mFull); end
      if (obsData !== mData) begin miscompares++; $display("[TB] FAIL rnd_data cyc=%0d got=%h exp=%h", cycleNo, obsData, mData); end
      if (obsGid !== 2'(mGid)) begin miscompares++; $display("[TB] FAIL rnd_gid cyc=%0d got=%0d exp=%0d", cycleNo, obsGid, mGid); end
      if (obsDrop !== 1'(mDrop)) begin miscompares++; $display("[TB] FAIL rnd_drop cyc=%0d got=%b exp=%b", cycleNo, obsDrop, mDrop); end
      if (obsStatGrant !== expStatGrant) begin miscompares++; $display("[TB] FAIL rnd_stat_grant cyc=%0d got=%h exp=%h", cycleNo, obsStatGrant, expStatGrant); end
      if (obsStatDrop !== expStatDrop) begin miscompares++; $display("[TB] FAIL rnd_stat_drop cyc=%0d got=%0d exp=%0d", cycleNo, obsStatDrop, expStatDrop); end
    end
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycleNo     = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_stall();
    test_drop();
    test_priority();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
